// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the PCI request arbiter.
//   arb_state_e : sequencer states
//   REQ_IO/MEM  : requester indices (bit positions in req_valid/req_done)
//   ABORT_DATA  : read data returned on master abort or watchdog expiry
//   pci_cmd_t   : command fields latched from the winning requester
package pci_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam logic REQ_IO  = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  localparam logic [DATA_W-1:0] ABORT_DATA = 32'hFFFF_FFFF;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
  } pci_cmd_t;

endpackage

// File: rtl/pci_arb_rr.sv
// Combinational 2-way round-robin picker.
//   req_valid   : per-requester request (bit 0 = I/O, bit 1 = mem)
//   rr_last     : index granted last time
//   grant_valid : some requester is asking
//   grant_idx   : winning requester index
module pci_arb_rr
  import pci_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       rr_last,
  output logic       grant_valid,
  output logic       grant_idx
);

  // On a tie the requester not served last time wins.
  always_comb begin
    grant_valid = |req_valid;
    if (&req_valid) begin
      grant_idx = ~rr_last;
    end else begin
      grant_idx = req_valid[REQ_MEM] ? REQ_MEM : REQ_IO;
    end
  end

endmodule

// File: rtl/pci_req_arbiter.sv
// Shares one pci_interface transaction engine between the CPU I/O-port
// path (index 0) and the Avalon memory path (index 1). Serialises requests
// round-robin, fires one single-cycle strobe per transaction, waits for the
// engine to finish (or aborts via trdy timeout / watchdog) and returns data
// and an error flag with a one-cycle req_done pulse.
//   clk, rst_n                 : clock, async active-low reset
//   req_*                      : requester side (valid/write/address/data/be)
//   req_done/readdata/err      : completion back to the winning requester
//   busy                       : sequencer not idle
//   pci_io_*/pci_mem_*         : single-cycle strobes to the engine
//   pci_address/writedata/be   : latched command fields
//   pci_wait/readdata(_valid)  : engine status
//   pci_trdy_timeout           : engine master-abort indication
module pci_req_arbiter
  import pci_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_address0,
  input  logic [ADDR_W-1:0] req_address1,
  input  logic [DATA_W-1:0] req_writedata0,
  input  logic [DATA_W-1:0] req_writedata1,
  input  logic [BE_W-1:0]   req_byteenable0,
  input  logic [BE_W-1:0]   req_byteenable1,
  output logic [1:0]        req_done,
  output logic [DATA_W-1:0] req_readdata,
  output logic              req_err,
  output logic              busy,
  output logic              pci_io_read,
  output logic              pci_io_write,
  output logic              pci_mem_read,
  output logic              pci_mem_write,
  output logic [ADDR_W-1:0] pci_address,
  output logic [DATA_W-1:0] pci_writedata,
  output logic [BE_W-1:0]   pci_byteenable,
  input  logic              pci_wait,
  input  logic [DATA_W-1:0] pci_readdata,
  input  logic              pci_readdata_valid,
  input  logic              pci_trdy_timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              idx_q, idx_d;
  pci_cmd_t          cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              io_rd_q, io_rd_d, io_wr_q, io_wr_d;
  logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              grant_valid;
  logic              grant_idx;
  logic              win_write;
  logic              wait_ok;
  logic              wait_abort;

  pci_arb_rr u_rr (
    .req_valid   (req_valid),
    .rr_last     (rr_last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign win_write = req_write[grant_idx];

  // cnt_q is 0 only in the first WAIT cycle, where pci_wait is not yet valid.
  assign wait_ok    = cmd_q.write ? ((cnt_q != '0) && !pci_wait) : pci_readdata_valid;
  assign wait_abort = pci_trdy_timeout || (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    idx_d     = idx_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    io_rd_d   = 1'b0;
    io_wr_d   = 1'b0;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    done_d    = 2'b00;
    rdata_d   = rdata_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          idx_d            = grant_idx;
          cmd_d.write      = win_write;
          cmd_d.address    = grant_idx ? req_address1    : req_address0;
          cmd_d.writedata  = grant_idx ? req_writedata1  : req_writedata0;
          cmd_d.byteenable = grant_idx ? req_byteenable1 : req_byteenable0;
          // Strobe is registered so it is high for exactly the ISSUE cycle.
          if (grant_idx == REQ_IO) begin
            io_rd_d = ~win_write;
            io_wr_d = win_write;
          end else begin
            mem_rd_d = ~win_write;
            mem_wr_d = win_write;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rr_last_d = idx_q;
        cnt_d     = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // Normal completion takes priority over an abort in the same cycle.
        if (wait_ok) begin
          rdata_d = cmd_q.write ? '0 : pci_readdata;
          err_d   = 1'b0;
          done_d  = idx_q ? 2'b10 : 2'b01;
          state_d = ST_DONE;
        end else if (wait_abort) begin
          rdata_d = ABORT_DATA;
          err_d   = 1'b1;
          done_d  = idx_q ? 2'b10 : 2'b01;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_last_q <= REQ_MEM;
      idx_q     <= REQ_IO;
      cmd_q     <= '0;
      cnt_q     <= '0;
      io_rd_q   <= 1'b0;
      io_wr_q   <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      idx_q     <= idx_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      io_rd_q   <= io_rd_d;
      io_wr_q   <= io_wr_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign req_done       = done_q;
  assign req_readdata   = rdata_q;
  assign req_err        = err_q;
  assign busy           = busy_q;
  assign pci_io_read    = io_rd_q;
  assign pci_io_write   = io_wr_q;
  assign pci_mem_read   = mem_rd_q;
  assign pci_mem_write  = mem_wr_q;
  assign pci_address    = cmd_q.address;
  assign pci_writedata  = cmd_q.writedata;
  assign pci_byteenable = cmd_q.byteenable;

endmodule

// File: tb/tb_pci_req_arbiter.sv
// Directed bench for pci_req_arbiter: a table of single-requester
// transactions plus hand-written arbitration, reset, stray-response and
// watchdog sequences. A second instance with an 8-cycle watchdog shares
// the inputs and is observed only in the watchdog sequence.
module tb_pci_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [31:0] req_address0 = '0, req_address1 = '0;
  logic [31:0] req_writedata0 = '0, req_writedata1 = '0;
  logic [3:0]  req_byteenable0 = '0, req_byteenable1 = '0;
  logic        pci_wait = 1'b0;
  logic [31:0] pci_readdata = '0;
  logic        pci_readdata_valid = 1'b0;
  logic        pci_trdy_timeout = 1'b0;

  logic [1:0]  a_done, b_done;
  logic [31:0] a_rdata, b_rdata, a_addr, b_addr, a_wd, b_wd;
  logic [3:0]  a_be, b_be;
  logic        a_err, b_err, a_busy, b_busy;
  logic        a_ior, a_iow, a_mr, a_mw, b_ior, b_iow, b_mr, b_mw;

  always #5 clk = ~clk;

  pci_req_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_address0(req_address0), .req_address1(req_address1),
    .req_writedata0(req_writedata0), .req_writedata1(req_writedata1),
    .req_byteenable0(req_byteenable0), .req_byteenable1(req_byteenable1),
    .req_done(a_done), .req_readdata(a_rdata), .req_err(a_err), .busy(a_busy),
    .pci_io_read(a_ior), .pci_io_write(a_iow), .pci_mem_read(a_mr), .pci_mem_write(a_mw),
    .pci_address(a_addr), .pci_writedata(a_wd), .pci_byteenable(a_be),
    .pci_wait(pci_wait), .pci_readdata(pci_readdata),
    .pci_readdata_valid(pci_readdata_valid), .pci_trdy_timeout(pci_trdy_timeout)
  );

  pci_req_arbiter #(.TIMEOUT_CYCLES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_address0(req_address0), .req_address1(req_address1),
    .req_writedata0(req_writedata0), .req_writedata1(req_writedata1),
    .req_byteenable0(req_byteenable0), .req_byteenable1(req_byteenable1),
    .req_done(b_done), .req_readdata(b_rdata), .req_err(b_err), .busy(b_busy),
    .pci_io_read(b_ior), .pci_io_write(b_iow), .pci_mem_read(b_mr), .pci_mem_write(b_mw),
    .pci_address(b_addr), .pci_writedata(b_wd), .pci_byteenable(b_be),
    .pci_wait(pci_wait), .pci_readdata(pci_readdata),
    .pci_readdata_valid(pci_readdata_valid), .pci_trdy_timeout(pci_trdy_timeout)
  );

  // Observed instance: strobes as {mem_wr, mem_rd, io_wr, io_rd}.
  logic        use8 = 1'b0;
  logic [3:0]  stb;
  logic [1:0]  o_done;
  logic [31:0] o_rdata, o_addr, o_wd;
  logic [3:0]  o_be;
  logic        o_err, o_busy;

  always_comb begin
    if (use8) begin
      stb = {b_mw, b_mr, b_iow, b_ior}; o_done = b_done; o_rdata = b_rdata;
      o_addr = b_addr; o_wd = b_wd; o_be = b_be; o_err = b_err; o_busy = b_busy;
    end else begin
      stb = {a_mw, a_mr, a_iow, a_ior}; o_done = a_done; o_rdata = a_rdata;
      o_addr = a_addr; o_wd = a_wd; o_be = a_be; o_err = a_err; o_busy = a_busy;
    end
  end

  int stb_cnt = 0;
  always @(negedge clk) stb_cnt <= stb_cnt + $countones(stb);

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    pci_wait = 1'b0; pci_readdata_valid = 1'b0; pci_trdy_timeout = 1'b0; pci_readdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input logic idx, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
    if (idx) begin
      req_address1 = addr; req_writedata1 = wd; req_byteenable1 = be;
    end else begin
      req_address0 = addr; req_writedata0 = wd; req_byteenable0 = be;
    end
    req_write[idx] = wr;
    req_valid[idx] = 1'b1;
  endtask

  // Waits for the strobe, plays the engine (read: valid at offset resp;
  // write: pci_wait high for offsets 1..resp; trdy timeout at offset trdy_at)
  // and checks the strobe, command fields, done latency and result.
  task automatic serve(input string nm, input logic idx, input logic wr,
                       input int resp, input int trdy_at, input logic [31:0] rdat,
                       input logic [3:0] exp_stb, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wd, input logic [3:0] exp_be,
                       input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
    int pre;
    int lat;
    pre = 0;
    lat = 0;
    while (stb == 4'b0 && pre < 8) begin
      tick();
      pre++;
    end
    chk({nm, " strobe_delay"}, 32'(pre), 32'd1);
    if (stb == 4'b0) return;
    chk({nm, " strobe"}, 32'(stb), 32'(exp_stb));
    chk({nm, " addr"}, o_addr, exp_addr);
    chk({nm, " be"}, 32'(o_be), 32'(exp_be));
    if (wr) chk({nm, " wdata"}, o_wd, exp_wd);
    chk({nm, " busy"}, 32'(o_busy), 32'd1);
    pci_wait = 1'b0; pci_readdata_valid = 1'b0; pci_trdy_timeout = 1'b0;
    for (int t = 1; t <= 300; t++) begin
      tick();
      if (t == 1) chk({nm, " strobe_1cyc"}, 32'(stb), 32'd0);
      if (o_done != 2'b00) begin
        lat = t;
        break;
      end
      pci_readdata_valid = !wr && (t == resp);
      pci_readdata       = (!wr && (t == resp)) ? rdat : 32'h0;
      pci_wait           = wr && (t <= resp);
      pci_trdy_timeout   = (t == trdy_at);
    end
    pci_wait = 1'b0; pci_readdata_valid = 1'b0; pci_trdy_timeout = 1'b0; pci_readdata = '0;
    chk({nm, " done_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " done"}, 32'(o_done), idx ? 32'd2 : 32'd1);
    chk({nm, " err"}, 32'(o_err), 32'(exp_err));
    if (!wr || exp_err) chk({nm, " rdata"}, o_rdata, exp_rd);
    req_valid[idx] = 1'b0;
    tick();
    chk({nm, " done_1cyc"}, 32'(o_done), 32'd0);
    chk({nm, " idle"}, 32'(o_busy), 32'd0);
  endtask

  typedef struct {
    logic        idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    int          resp;
    int          trdy;
    logic [31:0] rdat;
    logic [3:0]  exp_stb;
    int          exp_lat;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];
  int   base;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0CF8, 32'h0, 4'hF, 2, 0, 32'h8000_0000, 4'b0001, 3, 32'h8000_0000, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0CFC, 32'hA5A5_0001, 4'h3, 1, 0, 32'h0, 4'b0010, 3, 32'h0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'hC000_0100, 32'h0, 4'hF, 1, 0, 32'hDEAD_BEEF, 4'b0100, 2, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'hC000_0010, 32'h1234_5678, 4'hF, 0, 0, 32'h0, 4'b1000, 3, 32'h0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0CFC, 32'h0, 4'hC, 5, 0, 32'h1234_ABCD, 4'b0001, 6, 32'h1234_ABCD, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'hDFFF_FFFC, 32'h0BAD_CAFE, 4'h8, 4, 0, 32'h0, 4'b1000, 6, 32'h0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0CF8, 32'h0, 4'hF, 3, 3, 32'h5555_AAAA, 4'b0001, 4, 32'h5555_AAAA, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0CFC, 32'h0000_00FF, 4'h1, 50, 3, 32'h0, 4'b0010, 4, 32'hFFFF_FFFF, 1'b1};

    // Reset state.
    tick();
    chk("reset strobes", 32'(stb), 32'd0);
    chk("reset done", 32'(o_done), 32'd0);
    chk("reset data", o_rdata | o_addr | o_wd, 32'd0);
    chk("reset misc", 32'({o_be, o_err, o_busy}), 32'd0);
    do_reset();

    // Arbitration: both valid from reset -> I/O first, then mem; I/O
    // re-raised while mem pending -> mem wins that tie.
    set_req(1'b1, 1'b1, 32'hC000_0010, 32'h1234_5678, 4'hF);
    set_req(1'b0, 1'b0, 32'h0000_0CF8, 32'h0, 4'hF);
    serve("arb io", 1'b0, 1'b0, 1, 0, 32'h8000_0000, 4'b0001, 32'h0000_0CF8, 32'h0, 4'hF,
          2, 32'h8000_0000, 1'b0);
    set_req(1'b0, 1'b1, 32'h0000_0CFC, 32'hCAFE_F00D, 4'h1);
    serve("arb mem", 1'b1, 1'b1, 1, 0, 32'h0, 4'b1000, 32'hC000_0010, 32'h1234_5678, 4'hF,
          3, 32'h0, 1'b0);
    serve("arb io2", 1'b0, 1'b1, 1, 0, 32'h0, 4'b0010, 32'h0000_0CFC, 32'hCAFE_F00D, 4'h1,
          3, 32'h0, 1'b0);

    // Table of single-requester transactions.
    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].idx, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].be);
      serve($sformatf("vec%0d", i), vecs[i].idx, vecs[i].wr, vecs[i].resp, vecs[i].trdy,
            vecs[i].rdat, vecs[i].exp_stb, vecs[i].addr, vecs[i].wd, vecs[i].be,
            vecs[i].exp_lat, vecs[i].exp_rd, vecs[i].exp_err);
    end

    // Reset during WAIT, then the pending mem read is reissued once.
    do_reset();
    set_req(1'b1, 1'b0, 32'hC000_0200, 32'h0, 4'hF);
    tick();
    chk("rst pre strobe", 32'(stb), 32'b0100);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst async strobes", 32'({stb, o_done, o_err, o_busy}), 32'd0);
    chk("rst async data", o_rdata | o_addr | o_wd | 32'(o_be), 32'd0);
    base = stb_cnt;
    tick();
    tick();
    chk("rst held", 32'({stb, o_done, o_busy}), 32'd0);
    rst_n = 1'b1;
    serve("rst reissue", 1'b1, 1'b0, 2, 0, 32'h1357_9BDF, 4'b0100, 32'hC000_0200, 32'h0, 4'hF,
          3, 32'h1357_9BDF, 1'b0);
    chk("rst one strobe", 32'(stb_cnt - base), 32'd1);

    // Stray readdata_valid in IDLE, then a write stalled by pci_wait for 20 cycles.
    do_reset();
    pci_readdata = 32'h1111_1111;
    pci_readdata_valid = 1'b1;
    tick();
    pci_readdata_valid = 1'b0;
    pci_readdata = '0;
    chk("stray idle", 32'({o_done, o_busy, stb}), 32'd0);
    tick();
    chk("stray later", 32'({o_done, o_busy, stb}), 32'd0);
    set_req(1'b1, 1'b1, 32'hC000_0040, 32'hFEED_FACE, 4'hF);
    serve("wait20", 1'b1, 1'b1, 20, 0, 32'h0, 4'b1000, 32'hC000_0040, 32'hFEED_FACE, 4'hF,
          22, 32'h0, 1'b0);

    // Watchdog on the 8-cycle instance: no response at all.
    do_reset();
    use8 = 1'b1;
    set_req(1'b1, 1'b0, 32'hC000_0300, 32'h0, 4'hF);
    serve("wdog", 1'b1, 1'b0, 0, 0, 32'h0, 4'b0100, 32'hC000_0300, 32'h0, 4'hF,
          10, 32'hFFFF_FFFF, 1'b1);
    use8 = 1'b0;
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
